bp_me_l2_dma_prefetch_arbiter: RTL and testbench

- Per-bank arbiter that shares one L2 DMA channel between demand packets from bsg_cache and prefetch requests from the prefetch request queue.
- Demand always wins. A prefetch issues only when the channel is idle, a tracking slot is free, and the target stays in the trigger page.
- Returning fill beats are routed in order to the cache or to the prefetch block buffer, using a per-read destination tag FIFO.
- One instance sits per bank inside bp_me_cache_slice, between bsg_cache, the prefetch buffer and the DRAM DMA port.

---
 rtl/bp_me_l2_dma_prefetch_arbiter_pkg.sv | 14 +
 rtl/bp_me_l2_dma_prefetch_arbiter_if.sv | 13 +
 rtl/bp_me_l2_dma_prefetch_arbiter_return_router.sv | 79 +++++++
 rtl/bp_me_l2_dma_prefetch_arbiter.sv | 135 +++++++++++++
 tb/tb_bp_me_l2_dma_prefetch_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_me_l2_dma_prefetch_arbiter_pkg.sv
// Shared types for the per-bank L2 DMA demand/prefetch arbiter.
package bp_me_l2_dma_prefetch_arbiter_pkg;

  typedef enum logic {
    e_dest_demand   = 1'b0,
    e_dest_prefetch = 1'b1
  } bp_me_dma_dest_e;

  // bsg_cache_dma_pkt_s layout: {write_not_read, addr}
  function automatic int dma_pkt_width(input int daddr_width);
    return 1 + daddr_width;
  endfunction

endpackage

// File: rtl/bp_me_l2_dma_prefetch_arbiter_if.sv
// Valid/ready beat stream used on the DMA fill return path.
interface bp_me_l2_dma_prefetch_arbiter_if #(
  parameter int width_p = 64
) ();

  logic [width_p-1:0] data;
  logic               v;
  logic               ready_and;

  modport master (output data, output v, input ready_and);
  modport slave  (input data, input v, output ready_and);

endinterface

// File: rtl/bp_me_l2_dma_prefetch_arbiter_return_router.sv
// Destination tag FIFO, beat counter and fill demux: routes returning beats in
// read order to bsg_cache or to the prefetch block buffer.
module bp_me_l2_dma_prefetch_arbiter_return_router
  import bp_me_l2_dma_prefetch_arbiter_pkg::*;
#(
  parameter  int fills_per_block_p = 8,
  parameter  int max_outstanding_p = 4,
  localparam int occ_width_lp      = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             push_v_i,
  input  bp_me_dma_dest_e                  push_dest_i,
  bp_me_l2_dma_prefetch_arbiter_if.slave   dma_data_if,
  bp_me_l2_dma_prefetch_arbiter_if.master  demand_data_if,
  bp_me_l2_dma_prefetch_arbiter_if.master  pf_data_if,
  output logic [occ_width_lp-1:0]          occupancy_o,
  output logic                             idle_o
);

  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_width_lp = (fills_per_block_p > 1) ? $clog2(fills_per_block_p) : 1;

  bp_me_dma_dest_e         r_tags [max_outstanding_p];
  logic [ptr_width_lp-1:0] r_wr_ptr, r_rd_ptr;
  logic [occ_width_lp-1:0] r_count;
  logic [cnt_width_lp-1:0] r_beat;

  logic            w_empty, w_beat_acc, w_last, w_pop;
  bp_me_dma_dest_e w_head;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_head     = r_tags[r_rd_ptr];
  assign w_beat_acc = dma_data_if.v & dma_data_if.ready_and;
  assign w_last     = (r_beat == cnt_width_lp'(fills_per_block_p - 1));
  assign w_pop      = w_beat_acc & w_last;

  assign demand_data_if.data = dma_data_if.data;
  assign pf_data_if.data     = dma_data_if.data;
  assign demand_data_if.v    = dma_data_if.v & ~w_empty & (w_head == e_dest_demand);
  assign pf_data_if.v        = dma_data_if.v & ~w_empty & (w_head == e_dest_prefetch);
  assign dma_data_if.ready_and = ~w_empty &
    ((w_head == e_dest_demand) ? demand_data_if.ready_and : pf_data_if.ready_and);

  assign occupancy_o = r_count;
  assign idle_o      = w_empty & (r_beat == '0);

  // NOTE: tag storage is left unreset; r_count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_v_i) r_tags[r_wr_ptr] <= push_dest_i;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_beat   <= '0;
    end else begin
      if (push_v_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (push_v_i && !w_pop)      r_count <= r_count + occ_width_lp'(1);
      else if (!push_v_i && w_pop) r_count <= r_count - occ_width_lp'(1);
      if (w_beat_acc) r_beat <= w_last ? '0 : r_beat + cnt_width_lp'(1);
    end
  end

`ifndef SYNTHESIS
  a_no_beat_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    !(dma_data_if.v && w_empty))
    else $error("fill beat returned with no read outstanding");
`endif

endmodule

// File: rtl/bp_me_l2_dma_prefetch_arbiter.sv
// Per-bank arbiter sharing one L2 DMA channel between bsg_cache demand and prefetch.
// Optional statistics counters enabled by `define BP_ME_PF_ARB_STATS_EN.
module bp_me_l2_dma_prefetch_arbiter
  import bp_me_l2_dma_prefetch_arbiter_pkg::*;
#(
  parameter  int daddr_width_p       = 40,
  parameter  int l2_fill_width_p     = 64,
  parameter  int fills_per_block_p   = 8,
  parameter  int max_outstanding_p   = 4,
  parameter  int page_offset_width_p = 12,
  localparam int dma_pkt_width_lp    = dma_pkt_width(daddr_width_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [dma_pkt_width_lp-1:0] demand_pkt_i,
  input  logic                        demand_v_i,
  output logic                        demand_yumi_o,
  input  logic [dma_pkt_width_lp-1:0] pf_pkt_i,
  input  logic [daddr_width_p-1:0]    pf_base_addr_i,
  input  logic                        pf_v_i,
  output logic                        pf_yumi_o,
  input  logic                        pf_disable_i,
  output logic [dma_pkt_width_lp-1:0] dma_pkt_o,
  output logic                        dma_pkt_v_o,
  input  logic                        dma_pkt_ready_and_i,
  input  logic [l2_fill_width_p-1:0]  dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_ready_and_o,
  output logic [l2_fill_width_p-1:0]  demand_data_o,
  output logic                        demand_data_v_o,
  input  logic                        demand_data_ready_and_i,
  output logic [l2_fill_width_p-1:0]  pf_data_o,
  output logic                        pf_data_v_o,
  input  logic                        pf_data_ready_and_i,
  output logic                        idle_o,
  output logic [31:0]                 pf_issued_o,
  output logic [31:0]                 pf_dropped_o,
  output logic [31:0]                 demand_issued_o
);

  localparam int occ_width_lp = $clog2(max_outstanding_p + 1);

  logic [occ_width_lp-1:0] w_occupancy, w_free;
  logic w_demand_read, w_page_ok;
  logic w_demand_grant, w_pf_grant, w_pf_accept, w_pf_drop, w_push_v;
  bp_me_dma_dest_e w_push_dest;
  logic w_unused;

  assign w_unused = ^{pf_pkt_i[dma_pkt_width_lp-1], pf_base_addr_i[page_offset_width_p-1:0]};

  assign w_free        = occ_width_lp'(max_outstanding_p) - w_occupancy;
  assign w_demand_read = ~demand_pkt_i[dma_pkt_width_lp-1];
  assign w_page_ok     = (pf_pkt_i[daddr_width_p-1:page_offset_width_p]
                          == pf_base_addr_i[daddr_width_p-1:page_offset_width_p]);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_demand_grant = 1'b0;
    w_pf_grant     = 1'b0;
    dma_pkt_o      = '0;
    w_push_dest    = e_dest_demand;

    // Demand keeps the last slot to itself: prefetch needs two free.
    w_demand_grant = demand_v_i & (~w_demand_read | (w_free >= occ_width_lp'(1)));
    w_pf_grant     = ~demand_v_i & pf_v_i & ~pf_disable_i & w_page_ok
                   & (w_free >= occ_width_lp'(2));

    if (w_demand_grant)  dma_pkt_o = demand_pkt_i;
    else if (w_pf_grant) begin
      dma_pkt_o   = pf_pkt_i;
      w_push_dest = e_dest_prefetch;
    end
  end

  assign dma_pkt_v_o   = w_demand_grant | w_pf_grant;
  assign demand_yumi_o = w_demand_grant & dma_pkt_ready_and_i;
  assign w_pf_accept   = w_pf_grant & dma_pkt_ready_and_i;
  assign w_pf_drop     = pf_v_i & ~w_page_ok;
  assign pf_yumi_o     = w_pf_accept | w_pf_drop;
  assign w_push_v      = (demand_yumi_o & w_demand_read) | w_pf_accept;

  bp_me_l2_dma_prefetch_arbiter_if #(.width_p(l2_fill_width_p)) ret_if ();
  bp_me_l2_dma_prefetch_arbiter_if #(.width_p(l2_fill_width_p)) dem_if ();
  bp_me_l2_dma_prefetch_arbiter_if #(.width_p(l2_fill_width_p)) pf_if ();

  assign ret_if.data          = dma_data_i;
  assign ret_if.v             = dma_data_v_i;
  assign dma_data_ready_and_o = ret_if.ready_and;
  assign demand_data_o        = dem_if.data;
  assign demand_data_v_o      = dem_if.v;
  assign dem_if.ready_and     = demand_data_ready_and_i;
  assign pf_data_o            = pf_if.data;
  assign pf_data_v_o          = pf_if.v;
  assign pf_if.ready_and      = pf_data_ready_and_i;

  bp_me_l2_dma_prefetch_arbiter_return_router #(
    .fills_per_block_p (fills_per_block_p),
    .max_outstanding_p (max_outstanding_p)
  ) u_router (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .push_v_i       (w_push_v),
    .push_dest_i    (w_push_dest),
    .dma_data_if    (ret_if),
    .demand_data_if (dem_if),
    .pf_data_if     (pf_if),
    .occupancy_o    (w_occupancy),
    .idle_o         (idle_o)
  );

`ifdef BP_ME_PF_ARB_STATS_EN
  logic [31:0] r_pf_issued, r_pf_dropped, r_demand_issued;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pf_issued     <= '0;
      r_pf_dropped    <= '0;
      r_demand_issued <= '0;
    end else begin
      if (w_pf_accept   && r_pf_issued     != '1) r_pf_issued     <= r_pf_issued + 32'd1;
      if (w_pf_drop     && r_pf_dropped    != '1) r_pf_dropped    <= r_pf_dropped + 32'd1;
      if (demand_yumi_o && r_demand_issued != '1) r_demand_issued <= r_demand_issued + 32'd1;
    end
  end

  assign pf_issued_o     = r_pf_issued;
  assign pf_dropped_o    = r_pf_dropped;
  assign demand_issued_o = r_demand_issued;
`else
  assign pf_issued_o     = '0;
  assign pf_dropped_o    = '0;
  assign demand_issued_o = '0;
`endif

endmodule

// File: tb/tb_bp_me_l2_dma_prefetch_arbiter.sv
// Directed self-checking bench for bp_me_l2_dma_prefetch_arbiter.
module tb_bp_me_l2_dma_prefetch_arbiter;

  localparam int AW = 40;
  localparam int DW = 64;
  localparam int PW = AW + 1;
`ifdef BP_ME_PF_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic [PW-1:0] demand_pkt_i, pf_pkt_i, dma_pkt_o;
  logic [AW-1:0] pf_base_addr_i;
  logic          demand_v_i, demand_yumi_o, pf_v_i, pf_yumi_o, pf_disable_i;
  logic          dma_pkt_v_o, dma_pkt_ready_and_i;
  logic [DW-1:0] demand_data_o, pf_data_o;
  logic          demand_data_v_o, demand_data_ready_and_i;
  logic          pf_data_v_o, pf_data_ready_and_i, idle_o;
  logic [31:0]   pf_issued_o, pf_dropped_o, demand_issued_o;

  bp_me_l2_dma_prefetch_arbiter_if #(.width_p(DW)) ret_if ();

  bp_me_l2_dma_prefetch_arbiter dut (
    .clk_i                   (clk),
    .reset_i                 (reset_i),
    .demand_pkt_i            (demand_pkt_i),
    .demand_v_i              (demand_v_i),
    .demand_yumi_o           (demand_yumi_o),
    .pf_pkt_i                (pf_pkt_i),
    .pf_base_addr_i          (pf_base_addr_i),
    .pf_v_i                  (pf_v_i),
    .pf_yumi_o               (pf_yumi_o),
    .pf_disable_i            (pf_disable_i),
    .dma_pkt_o               (dma_pkt_o),
    .dma_pkt_v_o             (dma_pkt_v_o),
    .dma_pkt_ready_and_i     (dma_pkt_ready_and_i),
    .dma_data_i              (ret_if.data),
    .dma_data_v_i            (ret_if.v),
    .dma_data_ready_and_o    (ret_if.ready_and),
    .demand_data_o           (demand_data_o),
    .demand_data_v_o         (demand_data_v_o),
    .demand_data_ready_and_i (demand_data_ready_and_i),
    .pf_data_o               (pf_data_o),
    .pf_data_v_o             (pf_data_v_o),
    .pf_data_ready_and_i     (pf_data_ready_and_i),
    .idle_o                  (idle_o),
    .pf_issued_o             (pf_issued_o),
    .pf_dropped_o            (pf_dropped_o),
    .demand_issued_o         (demand_issued_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input logic wnr, input logic [AW-1:0] a);
    return {wnr, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input int dem, input int pfi, input int pfd);
    check("stat_demand", demand_issued_o, STATS ? 64'(dem) : 64'd0);
    check("stat_pf_iss", pf_issued_o,     STATS ? 64'(pfi) : 64'd0);
    check("stat_pf_drop", pf_dropped_o,   STATS ? 64'(pfd) : 64'd0);
  endtask

  // One-cycle demand issue with the channel idle enough to accept it.
  task automatic issue_demand(input logic wnr, input logic [AW-1:0] a);
    demand_pkt_i = pkt(wnr, a);
    demand_v_i   = 1'b1;
    #1;
    check("dem_pkt_v", dma_pkt_v_o, 1);
    check("dem_pkt", dma_pkt_o, pkt(wnr, a));
    check("dem_yumi", demand_yumi_o, 1);
    tick();
    demand_v_i = 1'b0;
  endtask

  task automatic send_beat(input bit to_pf, input logic [DW-1:0] d);
    ret_if.v    = 1'b1;
    ret_if.data = d;
    #1;
    check("ret_ready", ret_if.ready_and, 1);
    if (to_pf) begin
      check("pf_data", pf_data_o, d);
      check("pf_data_v", pf_data_v_o, 1);
      check("dem_data_v_off", demand_data_v_o, 0);
    end else begin
      check("dem_data", demand_data_o, d);
      check("dem_data_v", demand_data_v_o, 1);
      check("pf_data_v_off", pf_data_v_o, 0);
    end
    tick();
    ret_if.v = 1'b0;
  endtask

  task automatic send_block(input bit to_pf, input logic [DW-1:0] base, input bit idle_after);
    for (int i = 0; i < 8; i++) begin
      send_beat(to_pf, base + 64'(i));
      check(i == 7 ? "idle_end" : "idle_mid", idle_o, (i == 7) ? 64'(idle_after) : 64'd0);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    demand_pkt_i = '0; demand_v_i = 1'b0;
    pf_pkt_i = '0; pf_base_addr_i = '0; pf_v_i = 1'b0; pf_disable_i = 1'b0;
    dma_pkt_ready_and_i = 1'b1;
    demand_data_ready_and_i = 1'b1;
    pf_data_ready_and_i = 1'b1;
    ret_if.v = 1'b0; ret_if.data = '0;
    repeat (3) tick();
    check("rst_idle", idle_o, 1);
    check("rst_pkt_v", dma_pkt_v_o, 0);
    check("rst_ret_ready", ret_if.ready_and, 0);
    reset_i = 1'b0;
    tick();
    check_stats(0, 0, 0);

    // Demand read, 8 beats to the cache
    issue_demand(1'b0, 40'h8000);
    check("t1_busy", idle_o, 0);
    send_block(1'b0, 64'h100, 1'b1);
    check_stats(1, 0, 0);

    // Demand and in-page prefetch together: demand first, then prefetch
    demand_pkt_i   = pkt(1'b0, 40'h8100);
    demand_v_i     = 1'b1;
    pf_pkt_i       = pkt(1'b0, 40'h9040);
    pf_base_addr_i = 40'h9000;
    pf_v_i         = 1'b1;
    #1;
    check("t2_dem_pkt", dma_pkt_o, pkt(1'b0, 40'h8100));
    check("t2_dem_yumi", demand_yumi_o, 1);
    check("t2_pf_wait", pf_yumi_o, 0);
    tick();
    demand_v_i = 1'b0;
    #1;
    check("t2_pf_pkt_v", dma_pkt_v_o, 1);
    check("t2_pf_pkt", dma_pkt_o, pkt(1'b0, 40'h9040));
    check("t2_pf_yumi", pf_yumi_o, 1);
    tick();
    pf_v_i = 1'b0;
    send_block(1'b0, 64'h200, 1'b0);
    send_block(1'b1, 64'h300, 1'b1);
    check_stats(2, 1, 0);

    // Cross-page prefetch dropped, alone and alongside a demand issue
    pf_pkt_i       = pkt(1'b0, 40'hA000);
    pf_base_addr_i = 40'h9FC0;
    pf_v_i         = 1'b1;
    #1;
    check("t3_drop_yumi", pf_yumi_o, 1);
    check("t3_drop_no_pkt", dma_pkt_v_o, 0);
    tick();
    check_stats(2, 1, 1);
    demand_pkt_i = pkt(1'b0, 40'hE000);
    demand_v_i   = 1'b1;
    #1;
    check("t3_drop_yumi2", pf_yumi_o, 1);
    check("t3_dem_yumi", demand_yumi_o, 1);
    check("t3_dem_pkt", dma_pkt_o, pkt(1'b0, 40'hE000));
    tick();
    demand_v_i = 1'b0;
    pf_v_i     = 1'b0;
    send_block(1'b0, 64'h400, 1'b1);
    check_stats(3, 1, 2);

    // Slot limits: prefetch needs two free, demand read needs one, write none
    issue_demand(1'b0, 40'hB000);
    issue_demand(1'b0, 40'hB040);
    issue_demand(1'b0, 40'hB080);
    pf_pkt_i       = pkt(1'b0, 40'hB0C0);
    pf_base_addr_i = 40'hB000;
    pf_v_i         = 1'b1;
    #1;
    check("t4_pf_held", pf_yumi_o, 0);
    check("t4_pf_no_pkt", dma_pkt_v_o, 0);
    tick();
    demand_pkt_i = pkt(1'b0, 40'hB100);
    demand_v_i   = 1'b1;
    #1;
    check("t4_dem4_yumi", demand_yumi_o, 1);
    check("t4_dem4_pkt", dma_pkt_o, pkt(1'b0, 40'hB100));
    check("t4_pf_held2", pf_yumi_o, 0);
    tick();
    pf_v_i       = 1'b0;
    demand_pkt_i = pkt(1'b0, 40'hB140);
    #1;
    check("t4_full_no_pkt", dma_pkt_v_o, 0);
    check("t4_full_no_yumi", demand_yumi_o, 0);
    demand_pkt_i = pkt(1'b1, 40'hB180);
    #1;
    check("t4_wr_pkt_v", dma_pkt_v_o, 1);
    check("t4_wr_pkt", dma_pkt_o, pkt(1'b1, 40'hB180));
    check("t4_wr_yumi", demand_yumi_o, 1);
    tick();
    demand_pkt_i = pkt(1'b0, 40'hB140);
    for (int i = 0; i < 8; i++) begin
      send_beat(1'b0, 64'h500 + 64'(i));
      check("t4_stall_yumi", demand_yumi_o, (i == 7) ? 64'd1 : 64'd0);
    end
    tick();
    demand_v_i = 1'b0;
    send_block(1'b0, 64'h600, 1'b0);
    send_block(1'b0, 64'h700, 1'b0);
    send_block(1'b0, 64'h800, 1'b0);
    send_block(1'b0, 64'h900, 1'b1);
    check_stats(9, 1, 2);

    // Prefetch quiesce, then backpressure from the prefetch buffer mid-block
    pf_pkt_i       = pkt(1'b0, 40'hC040);
    pf_base_addr_i = 40'hC000;
    pf_v_i         = 1'b1;
    pf_disable_i   = 1'b1;
    #1;
    check("t5_disabled_yumi", pf_yumi_o, 0);
    check("t5_disabled_pkt", dma_pkt_v_o, 0);
    pf_disable_i = 1'b0;
    #1;
    check("t5_pf_pkt", dma_pkt_o, pkt(1'b0, 40'hC040));
    check("t5_pf_yumi", pf_yumi_o, 1);
    tick();
    pf_v_i = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(1'b1, 64'hA00 + 64'(i));
    pf_data_ready_and_i = 1'b0;
    ret_if.v    = 1'b1;
    ret_if.data = 64'hA03;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_bp_ready", ret_if.ready_and, 0);
      check("t5_bp_pf_v", pf_data_v_o, 1);
      check("t5_bp_dem_v", demand_data_v_o, 0);
      tick();
    end
    pf_data_ready_and_i = 1'b1;
    for (int i = 3; i < 8; i++) begin
      send_beat(1'b1, 64'hA00 + 64'(i));
      check("t5_resume_idle", idle_o, (i == 7) ? 64'd1 : 64'd0);
    end
    check_stats(9, 2, 2);

    // Reset in the middle of a block, then a clean demand read
    issue_demand(1'b0, 40'hD000);
    for (int i = 0; i < 3; i++) send_beat(1'b0, 64'hB00 + 64'(i));
    check("t6_pre_rst_idle", idle_o, 0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("t6_rst_idle", idle_o, 1);
    check("t6_rst_ret_ready", ret_if.ready_and, 0);
    check_stats(0, 0, 0);
    issue_demand(1'b0, 40'hD040);
    send_block(1'b0, 64'hC00, 1'b1);
    check_stats(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
